multicycle_alu: RTL and testbench

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

---
 rtl/multicycle_alu.sv | 122 ++++++++++++
 tb/tb_multicycle_alu.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle add/sub/and/or/sltu/slt, iterative
// one-bit-per-cycle sll/srl. Handshake is start -> done pulse. busy is high
// while a shift is in progress.
module multicycle_alu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            aluControl,
  input  logic [DATA_WIDTH-1:0] srcA,
  input  logic [DATA_WIDTH-1:0] srcB,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] aluResult,
  output logic                  zero
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Same encoding as the ALU decoder.
  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_SLTU = 3'b100,
    OP_SLT  = 3'b101,
    OP_SLL  = 3'b110,
    OP_SRL  = 3'b111
  } op_t;

  state_t                  state;
  state_t                  next_state;
  op_t                     op;
  logic [4:0]              shamt;
  logic [4:0]              count;
  logic                    shift_left;
  logic [DATA_WIDTH-1:0]   acc;
  logic [DATA_WIDTH-1:0]   comb_result;
  logic                    accept;
  logic                    is_shift;
  logic                    start_shift;

  assign op          = op_t'(aluControl);
  // Only the low five bits of srcB matter for shifts; the rest are ignored.
  assign shamt       = srcB[4:0];
  // A new request is taken in IDLE and in DONE (back-to-back), never mid-shift.
  assign accept      = start && (state != SHIFT);
  assign is_shift    = (op == OP_SLL) || (op == OP_SRL);
  assign start_shift = accept && is_shift && (shamt != 5'd0);

  // Single-cycle result for every op; a shift by zero passes srcA through.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    comb_result = '0;
    unique case (op)
      OP_ADD:  comb_result = srcA + srcB;
      OP_SUB:  comb_result = srcA - srcB;
      OP_AND:  comb_result = srcA & srcB;
      OP_OR:   comb_result = srcA | srcB;
      OP_SLTU: comb_result = {{(DATA_WIDTH-1){1'b0}}, (srcA < srcB)};
      OP_SLT:  comb_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
      OP_SLL:  comb_result = srcA;
      OP_SRL:  comb_result = srcA;
      default: comb_result = '0;
    endcase
  end

  // Next-state logic: DONE behaves like IDLE for accepting a new request.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE, DONE: begin
        if (accept) next_state = start_shift ? SHIFT : DONE;
        else        next_state = IDLE;
      end
      SHIFT: begin
        // count holds the shifts still to do, including the one this cycle.
        if (count == 5'd1) next_state = DONE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State register; reset takes effect immediately, independent of the clock.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Datapath: load result or shift seed on accept, one bit per SHIFT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      count      <= 5'd0;
      shift_left <= 1'b0;
    end else if (state == SHIFT) begin
      acc   <= shift_left ? (acc << 1) : (acc >> 1);
      count <= count - 5'd1;
    end else if (accept) begin
      acc <= comb_result;
      if (start_shift) begin
        count      <= shamt;
        shift_left <= (op == OP_SLL);
      end
    end
  end

  assign busy      = (state == SHIFT);
  assign done      = (state == DONE);
  assign aluResult = acc;
  assign zero      = (acc == '0);

endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu: the driver pushes the expected result
// and done cycle for every accepted op; a negedge monitor pops and compares.
module tb_multicycle_alu;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011,
                         SLTU = 3'b100, SLT = 3'b101, SLL = 3'b110, SRL = 3'b111;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  aluControl = 3'b000;
  logic [31:0] srcA = '0;
  logic [31:0] srcB = '0;
  logic        busy, done, zero;
  logic [31:0] aluResult;

  int   cyc = 0;
  int   busy_lo = 1;
  int   busy_hi = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  multicycle_alu #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .aluControl(aluControl),
    .srcA(srcA), .srcB(srcB), .busy(busy), .done(done),
    .aluResult(aluResult), .zero(zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      ADD:     return a + b;
      SUB:     return a - b;
      AND_:    return a & b;
      OR_:     return a | b;
      SLTU:    return (a < b) ? 32'd1 : 32'd0;
      SLT:     return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      SLL:     return a << b[4:0];
      default: return a >> b[4:0];
    endcase
  endfunction

  // Monitor: busy window every cycle; result, zero and timing on each done.
  always @(negedge clk) begin
    exp_t e;
    check("busy", busy, (cyc >= busy_lo) && (cyc <= busy_hi));
    if (done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", done, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("result", aluResult, e.res);
        check("zero", zero, e.res == 32'd0);
        check("done_cycle", cyc, e.cyc);
      end
    end else if (exp_q.size() != 0 && cyc >= exp_q[0].cyc) begin
      check("missing_done", done, 1'b1);
      void'(exp_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an op in the current cycle and record what must come back.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    int k;
    exp_t e;
    k = (op == SLL || op == SRL) ? int'(b[4:0]) : 0;
    lat = 1 + k;
    start = 1'b1;
    aluControl = op;
    srcA = a;
    srcB = b;
    e.res = model(op, a, b);
    e.cyc = cyc + lat;
    exp_q.push_back(e);
    if (k > 0) begin
      busy_lo = cyc + 1;
      busy_hi = cyc + k;
    end
  endtask

  // Issue, scramble inputs after the accept edge, return in the done cycle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int lat;
    issue(op, a, b, lat);
    step();
    start = 1'b0;
    aluControl = 3'($urandom);
    srcA = $urandom;
    srcB = $urandom;
    repeat (lat - 1) step();
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    int lat;
    #1 rst = 1'b1;
    #2;
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_result", aluResult, 32'd0);
    check("reset_zero", zero, 1'b1);
    repeat (3) step();
    rst = 1'b0;

    // add right after reset release, then result held through idle cycles.
    run_op(ADD, 32'h7FFF_FFFF, 32'd1);
    idle(3);
    check("held_after_done", aluResult, 32'h8000_0000);

    // sub, slt, sltu back-to-back; each issued in the previous done cycle.
    run_op(SUB, 32'd5, 32'd5);
    run_op(SLT, 32'hFFFF_FFFF, 32'd1);
    run_op(SLTU, 32'hFFFF_FFFF, 32'd1);
    run_op(AND_, 32'hF0F0_1234, 32'h0FF0_FF00);
    run_op(OR_, 32'hF000_0001, 32'h0000_0F10);
    run_op(SUB, 32'd0, 32'd1);
    idle(1);

    // sll by 5 (upper srcB bits set) with a stray start during the shift.
    issue(SLL, 32'd1, 32'h0000_0025, lat);
    step();
    start = 1'b0;
    step();
    start = 1'b1;
    aluControl = ADD;
    srcA = 32'd3;
    srcB = 32'd4;
    step();
    start = 1'b0;
    repeat (lat - 3) step();
    idle(1);

    // srl by 31, then srl by 0 with nonzero upper srcB bits.
    run_op(SRL, 32'h8000_0000, 32'd31);
    run_op(SRL, 32'hDEAD_BEEF, 32'hFFFF_FFE0);
    run_op(SLL, 32'h8000_0001, 32'd1);
    idle(2);

    // Reset mid-shift: abort, outputs clear at once, no done afterwards.
    issue(SLL, 32'h0000_0003, 32'd20, lat);
    step();
    start = 1'b0;
    repeat (6) step();
    #2;
    busy_lo = 1;
    busy_hi = 0;
    exp_q.delete();
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_result", aluResult, 32'd0);
    check("abort_zero", zero, 1'b1);
    repeat (2) step();
    rst = 1'b0;
    run_op(ADD, 32'd10, 32'd32);
    idle(3);

    // Random ops, mostly back-to-back, against the reference model.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a, b;
      logic [2:0]  op;
      op = 3'($urandom);
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if (op == SLL || op == SRL) b = {$urandom, 5'(b)} >> 5 << 5 | 32'(b[4:0]);
      run_op(op, a, b);
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end

    idle(3);
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
